// File: rtl/alien_field_controller_pkg.sv
// alien_field_controller_pkg
// Shared definitions for the alien slot array: slot count, slot record
// layout, frame_num encoding and the controller FSM state enum.
package alien_field_controller_pkg;

  localparam int OBJ_LIMIT = 8;
  localparam int IDX_W     = $clog2(OBJ_LIMIT);

  // _frame_num encoding: values <= ALIVE1 are alive animation frames,
  // DYING0/DYING1 are the two explosion frames before the slot is freed.
  localparam logic [1:0] ALIVE0 = 2'd0;
  localparam logic [1:0] ALIVE1 = 2'd1;
  localparam logic [1:0] DYING0 = 2'd2;
  localparam logic [1:0] DYING1 = 2'd3;

  typedef struct packed {
    logic       _valid;
    logic [3:0] _r;
    logic [7:0] _theta;
    logic [1:0] _type;
    logic [1:0] _frame_num;
  } AlienData;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SPAWN = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/alien_field_controller_free_slot_finder.sv
// alien_field_controller_free_slot_finder
// Combinational priority encoder over the slot valid bits.
// Ports:
//   valid_vec  in   one bit per slot, 1 = occupied
//   free_idx   out  lowest index whose valid bit is 0 (0 when full)
//   full       out  1 when every slot is occupied
module alien_field_controller_free_slot_finder
  import alien_field_controller_pkg::*;
(
  input  logic [OBJ_LIMIT-1:0] valid_vec,
  output logic [IDX_W-1:0]     free_idx,
  output logic                 full
);

  // Walk from the top down so the lowest free index is written last.
  always_comb begin
    free_idx = '0;
    full     = 1'b1;
    for (int i = OBJ_LIMIT - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_idx = IDX_W'(i);
        full     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alien_field_controller.sv
// alien_field_controller
// Owns the alien slot array: spawns into free slots, advances and animates
// aliens once per frame, and runs the hit -> explode -> free sequence.
// Optional build macro: ALIEN_SPEEDUP_EN (every 8th kill shortens the
// advance period by one frame, floor 1). Slot count comes from the package.
// Ports:
//   clk_100MHz, rst           clock, synchronous active-high reset
//   frame_tick                one-cycle pulse per video frame
//   spawn_req/type/theta      spawn request, held until spawn_ack
//   spawn_ack, spawn_ok       one-cycle acceptance; ok=0 means field full
//   hit_req, hit_idx          one-cycle hit pulse and target slot
//   obj_data                  registered slot array
//   breach, kill              one-cycle event pulses
//   alive_count               registered count of valid slots
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | apply pending hit; wait for frame_tick (priority) or spawn
// ST_SCAN  | update one slot per cycle, idx 0..OBJ_LIMIT-1
// ST_SPAWN | write the lowest free slot (or refuse), ack, back to IDLE
module alien_field_controller
  import alien_field_controller_pkg::*;
#(
  parameter int R_MAX       = 15,
  parameter int ADV_PERIOD  = 4,
  parameter int ANIM_PERIOD = 2
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             spawn_req,
  input  logic [1:0]       spawn_type,
  input  logic [7:0]       spawn_theta,
  output logic             spawn_ack,
  output logic             spawn_ok,
  input  logic             hit_req,
  input  logic [IDX_W-1:0] hit_idx,
  output AlienData         obj_data [OBJ_LIMIT],
  output logic             breach,
  output logic             kill,
  output logic [IDX_W:0]   alive_count
);

  localparam int FC_W = 8;

  fsm_state_e       state_q, state_d;
  AlienData         obj_q [OBJ_LIMIT];
  AlienData         obj_d [OBJ_LIMIT];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             anim_phase_q, anim_phase_d;
  logic             adv_q, adv_d;
  logic             hit_pend_q, hit_pend_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [IDX_W:0]   alive_count_q, alive_count_d;

  logic [OBJ_LIMIT-1:0] valid_vec;
  logic [IDX_W-1:0]     free_idx;
  logic                 full;
  logic [FC_W-1:0]      adv_period;
  AlienData             slot_c;
  logic                 kill_c, breach_c, ack_c, ok_c;

  always_comb begin
    for (int i = 0; i < OBJ_LIMIT; i++) valid_vec[i] = obj_q[i]._valid;
  end

  alien_field_controller_free_slot_finder u_free_slot_finder (
    .valid_vec (valid_vec),
    .free_idx  (free_idx),
    .full      (full)
  );

  always_comb begin
    state_d      = state_q;
    obj_d        = obj_q;
    idx_d        = idx_q;
    frame_cnt_d  = frame_cnt_q;
    anim_phase_d = anim_phase_q;
    adv_d        = adv_q;
    hit_pend_d   = hit_pend_q;
    pend_idx_d   = pend_idx_q;
    slot_c       = obj_q[idx_q];
    kill_c       = 1'b0;
    breach_c     = 1'b0;
    ack_c        = 1'b0;
    ok_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The pending hit lands before this cycle's tick/spawn decision,
        // so a scan started now sees the post-hit slot.
        if (hit_pend_q) begin
          hit_pend_d = 1'b0;
          if (obj_q[pend_idx_q]._valid && obj_q[pend_idx_q]._frame_num <= ALIVE1) begin
            obj_d[pend_idx_q]._frame_num = DYING0;
            kill_c = 1'b1;
          end
        end
        if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + FC_W'(1);
          adv_d       = ((frame_cnt_d % adv_period) == '0);
          if ((frame_cnt_d % FC_W'(ANIM_PERIOD)) == '0) anim_phase_d = ~anim_phase_q;
          idx_d   = '0;
          state_d = ST_SCAN;
        end else if (spawn_req) begin
          state_d = ST_SPAWN;
        end
      end

      ST_SCAN: begin
        if (slot_c._valid) begin
          if (slot_c._frame_num <= ALIVE1) begin
            slot_c._frame_num = {1'b0, anim_phase_q};
            if (adv_q) begin
              if (slot_c._r != '0) begin
                slot_c._r = slot_c._r - 4'd1;
              end else begin
                slot_c._valid = 1'b0;
                breach_c      = 1'b1;
              end
            end
          end else if (slot_c._frame_num == DYING0) begin
            slot_c._frame_num = DYING1;
          end else begin
            slot_c._valid     = 1'b0;
            slot_c._frame_num = ALIVE0;
          end
        end
        obj_d[idx_q] = slot_c;
        if (idx_q == IDX_W'(OBJ_LIMIT - 1)) state_d = ST_IDLE;
        else                                idx_d   = idx_q + IDX_W'(1);
      end

      ST_SPAWN: begin
        ack_c = 1'b1;
        ok_c  = ~full;
        if (!full) begin
          obj_d[free_idx] = '{_valid: 1'b1, _r: 4'(R_MAX), _theta: spawn_theta,
                              _type: spawn_type, _frame_num: {1'b0, anim_phase_q}};
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Capture last so a new hit overwrites one being consumed this cycle.
    if (hit_req) begin
      hit_pend_d = 1'b1;
      pend_idx_d = hit_idx;
    end
  end

  always_comb begin
    alive_count_d = '0;
    for (int i = 0; i < OBJ_LIMIT; i++)
      alive_count_d = alive_count_d + {{IDX_W{1'b0}}, obj_q[i]._valid};
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < OBJ_LIMIT; i++) obj_q[i] <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      anim_phase_q  <= 1'b0;
      adv_q         <= 1'b0;
      hit_pend_q    <= 1'b0;
      pend_idx_q    <= '0;
      alive_count_q <= '0;
    end else begin
      state_q       <= state_d;
      obj_q         <= obj_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      anim_phase_q  <= anim_phase_d;
      adv_q         <= adv_d;
      hit_pend_q    <= hit_pend_d;
      pend_idx_q    <= pend_idx_d;
      alive_count_q <= alive_count_d;
    end
  end

`ifdef ALIEN_SPEEDUP_EN
  logic [2:0]      kill_cnt_q, kill_cnt_d;
  logic [FC_W-1:0] adv_period_q, adv_period_d;

  always_comb begin
    kill_cnt_d   = kill_cnt_q;
    adv_period_d = adv_period_q;
    if (kill_c) begin
      kill_cnt_d = kill_cnt_q + 3'd1;
      if (kill_cnt_q == 3'd7 && adv_period_q > FC_W'(1)) adv_period_d = adv_period_q - FC_W'(1);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      kill_cnt_q   <= '0;
      adv_period_q <= FC_W'(ADV_PERIOD);
    end else begin
      kill_cnt_q   <= kill_cnt_d;
      adv_period_q <= adv_period_d;
    end
  end

  assign adv_period = adv_period_q;
`else
  assign adv_period = FC_W'(ADV_PERIOD);
`endif

  // Pulses are decoded from registered state; held low while in reset.
  assign spawn_ack   = ack_c & ~rst;
  assign spawn_ok    = ok_c & ~rst;
  assign kill        = kill_c & ~rst;
  assign breach      = breach_c & ~rst;
  assign obj_data    = obj_q;
  assign alive_count = alive_count_q;

endmodule

// File: tb/tb_alien_field_controller.sv
module tb_alien_field_controller;
  import alien_field_controller_pkg::*;

  localparam int R_MAX       = 15;
  localparam int ADV_PERIOD  = 4;
  localparam int ANIM_PERIOD = 2;

  logic             clk_100MHz = 1'b0;
  logic             rst, frame_tick, spawn_req, hit_req;
  logic [1:0]       spawn_type;
  logic [7:0]       spawn_theta;
  logic [IDX_W-1:0] hit_idx;
  logic             spawn_ack, spawn_ok, breach, kill;
  logic [IDX_W:0]   alive_count;
  AlienData         obj_data [OBJ_LIMIT];

  always #5 clk_100MHz = ~clk_100MHz;

  alien_field_controller #(
    .R_MAX(R_MAX), .ADV_PERIOD(ADV_PERIOD), .ANIM_PERIOD(ANIM_PERIOD)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .spawn_req   (spawn_req),
    .spawn_type  (spawn_type),
    .spawn_theta (spawn_theta),
    .spawn_ack   (spawn_ack),
    .spawn_ok    (spawn_ok),
    .hit_req     (hit_req),
    .hit_idx     (hit_idx),
    .obj_data    (obj_data),
    .breach      (breach),
    .kill        (kill),
    .alive_count (alive_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: plain per-slot arrays updated per transaction.
  int m_valid [OBJ_LIMIT];
  int m_r     [OBJ_LIMIT];
  int m_theta [OBJ_LIMIT];
  int m_type  [OBJ_LIMIT];
  int m_fn    [OBJ_LIMIT];
  int m_frames;
  int m_anim;

  typedef enum int {OP_SPAWN, OP_HIT, OP_TICK, OP_TICKN} op_e;
  typedef struct {
    op_e op;
    int  a;
    int  b;
    int  exp_flag;
    int  exp_alive;
    int  exp_r0;
  } vec_t;
  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < OBJ_LIMIT; i++) begin
      m_valid[i] = 0; m_r[i] = 0; m_theta[i] = 0; m_type[i] = 0; m_fn[i] = 0;
    end
    m_frames = 0;
    m_anim   = 0;
  endtask

  task automatic model_spawn(input int t, input int th, output int ok);
    ok = 0;
    for (int i = 0; i < OBJ_LIMIT; i++) begin
      if (ok == 0 && m_valid[i] == 0) begin
        m_valid[i] = 1; m_r[i] = R_MAX; m_theta[i] = th; m_type[i] = t; m_fn[i] = m_anim;
        ok = 1;
      end
    end
  endtask

  task automatic model_hit(input int idx, output int kills);
    kills = 0;
    if (m_valid[idx] != 0 && m_fn[idx] < 2) begin
      m_fn[idx] = 2;
      kills = 1;
    end
  endtask

  task automatic model_tick(output int breaches);
    int adv;
    breaches = 0;
    m_frames++;
    adv = (m_frames % ADV_PERIOD == 0);
    if (m_frames % ANIM_PERIOD == 0) m_anim = 1 - m_anim;
    for (int i = 0; i < OBJ_LIMIT; i++) begin
      if (m_valid[i] != 0) begin
        if (m_fn[i] < 2) begin
          m_fn[i] = m_anim;
          if (adv != 0) begin
            if (m_r[i] > 0) m_r[i]--;
            else begin m_valid[i] = 0; breaches++; end
          end
        end else if (m_fn[i] == 2) begin
          m_fn[i] = 3;
        end else begin
          m_valid[i] = 0; m_fn[i] = 0;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] a, e;
    int cnt;
    cnt = 0;
    for (int i = 0; i < OBJ_LIMIT; i++) begin
      a = {15'd0, obj_data[i]._valid, obj_data[i]._r, obj_data[i]._theta,
           obj_data[i]._type, obj_data[i]._frame_num};
      e = {15'd0, m_valid[i][0], m_r[i][3:0], m_theta[i][7:0], m_type[i][1:0], m_fn[i][1:0]};
      check($sformatf("%s slot%0d", tag, i), a, e);
      cnt += m_valid[i];
    end
    check($sformatf("%s alive_count", tag), 32'(alive_count), cnt);
  endtask

  task automatic do_spawn(input logic [1:0] t, input logic [7:0] th, output int ok);
    int seen;
    seen = 0;
    ok   = 0;
    spawn_req = 1'b1; spawn_type = t; spawn_theta = th;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk_100MHz);
      if (spawn_ack) begin seen = 1; ok = int'(spawn_ok); end
    end
    spawn_req = 1'b0;
    check("spawn_ack seen", seen, 1);
    repeat (3) @(negedge clk_100MHz);
  endtask

  task automatic do_hit(input int idx, output int kills);
    kills = 0;
    for (int k = 0; k < 6; k++) begin
      hit_req = (k == 0);
      hit_idx = IDX_W'(idx);
      @(negedge clk_100MHz);
      kills += int'(kill);
    end
  endtask

  // extras: a hit on hidx and a stray frame_tick are injected mid-scan.
  task automatic do_tick(input int extras, input int hidx, output int br, output int kl);
    br = 0; kl = 0;
    for (int k = 0; k < 15; k++) begin
      frame_tick = (k == 0) || (extras != 0 && k == 4);
      hit_req    = (extras != 0 && k == 3);
      hit_idx    = IDX_W'(hidx);
      @(negedge clk_100MHz);
      br += int'(breach);
      kl += int'(kill);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, br, kl, exp_br, exp_kl, pulses, sel, t, th, hidx;
    vec_t v;

    tbl[0]  = '{OP_SPAWN, 2, 40,  1, 1, 15};
    tbl[1]  = '{OP_TICKN, 8, 0,   0, 1, 13};
    tbl[2]  = '{OP_SPAWN, 1, 10,  1, 2, -1};
    tbl[3]  = '{OP_SPAWN, 3, 20,  1, 3, -1};
    tbl[4]  = '{OP_SPAWN, 0, 30,  1, 4, -1};
    tbl[5]  = '{OP_SPAWN, 2, 50,  1, 5, -1};
    tbl[6]  = '{OP_SPAWN, 1, 60,  1, 6, -1};
    tbl[7]  = '{OP_SPAWN, 3, 70,  1, 7, -1};
    tbl[8]  = '{OP_SPAWN, 0, 80,  1, 8, -1};
    tbl[9]  = '{OP_SPAWN, 2, 90,  0, 8, -1};
    tbl[10] = '{OP_HIT,   3, 0,   1, 8, -1};
    tbl[11] = '{OP_HIT,   3, 0,   0, 8, -1};
    tbl[12] = '{OP_TICK,  0, 0,   0, 8, -1};
    tbl[13] = '{OP_HIT,   3, 0,   0, 8, -1};
    tbl[14] = '{OP_TICK,  0, 0,   0, 7, -1};
    tbl[15] = '{OP_HIT,   3, 0,   0, 7, -1};
    tbl[16] = '{OP_SPAWN, 1, 99,  1, 8, -1};
    tbl[17] = '{OP_TICKN, 53, 0,  0, 8, 0};
    tbl[18] = '{OP_TICK,  0, 0,   1, 7, -1};
    tbl[19] = '{OP_SPAWN, 3, 123, 1, 8, 15};

    rst = 1'b1; frame_tick = 1'b0; spawn_req = 1'b0; hit_req = 1'b0;
    spawn_type = '0; spawn_theta = '0; hit_idx = '0;
    model_reset();
    repeat (3) @(negedge clk_100MHz);
    check("reset spawn_ack", spawn_ack, 0);
    check("reset kill", kill, 0);
    check("reset breach", breach, 0);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk_100MHz);

    // Directed scenario table.
    for (int s = 0; s < 20; s++) begin
      v = tbl[s];
      got = 0;
      case (v.op)
        OP_SPAWN: begin
          do_spawn(2'(v.a), 8'(v.b), got);
          model_spawn(v.a, v.b, exp_kl);
        end
        OP_HIT: begin
          do_hit(v.a, got);
          model_hit(v.a, exp_kl);
        end
        OP_TICK: begin
          do_tick(0, 0, got, kl);
          model_tick(exp_br);
        end
        default: begin
          for (int n = 0; n < v.a; n++) begin
            do_tick(0, 0, br, kl);
            got += br;
            model_tick(exp_br);
          end
        end
      endcase
      check($sformatf("vec%0d flag", s), got, v.exp_flag);
      check($sformatf("vec%0d alive_count", s), 32'(alive_count), v.exp_alive);
      if (v.exp_r0 >= 0) check($sformatf("vec%0d slot0 r", s), 32'(obj_data[0]._r), v.exp_r0);
      check_state($sformatf("vec%0d", s));
    end
    check("reused slot0 theta", 32'(obj_data[0]._theta), 123);

    // Pending hit and frame_tick in the same IDLE cycle: slot 0 is hit and
    // then advanced from DYING0 to DYING1 by the scan it starts.
    kl = 0;
    for (int k = 0; k < 16; k++) begin
      hit_req    = (k == 0);
      hit_idx    = '0;
      frame_tick = (k == 1);
      @(negedge clk_100MHz);
      kl += int'(kill);
    end
    model_hit(0, exp_kl);
    model_tick(exp_br);
    check("hit+tick kill", kl, 1);
    check("hit+tick slot0 frame_num", 32'(obj_data[0]._frame_num), 3);
    check_state("hit+tick");

    // Reset mid-scan with a pending hit, plus hit/tick in the reset cycle.
    frame_tick = 1'b1;
    @(negedge clk_100MHz);
    frame_tick = 1'b0;
    @(negedge clk_100MHz);
    hit_req = 1'b1; hit_idx = IDX_W'(1);
    @(negedge clk_100MHz);
    hit_req = 1'b0;
    @(negedge clk_100MHz);
    rst = 1'b1; hit_req = 1'b1; frame_tick = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100MHz);
      hit_req = 1'b0; frame_tick = 1'b0;
      pulses += int'(kill) + int'(breach) + int'(spawn_ack);
    end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_100MHz);
      pulses += int'(kill) + int'(breach) + int'(spawn_ack);
    end
    model_reset();
    check("reset pulses", pulses, 0);
    check_state("mid-scan reset");

    // Frame counter restarted: fourth tick after reset advances once.
    do_spawn(2'd1, 8'd77, got);
    model_spawn(1, 77, exp_kl);
    check("post-reset spawn_ok", got, 1);
    for (int n = 0; n < 4; n++) begin
      do_tick(0, 0, br, kl);
      model_tick(exp_br);
    end
    check("post-reset slot0 r", 32'(obj_data[0]._r), 14);
    check_state("post-reset ticks");

    // Random transactions against the model.
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 35) begin
        t  = $urandom_range(0, 3);
        th = $urandom_range(0, 255);
        do_spawn(2'(t), 8'(th), got);
        model_spawn(t, th, exp_kl);
        check("rand spawn_ok", got, exp_kl);
      end else if (sel < 60) begin
        hidx = $urandom_range(0, OBJ_LIMIT - 1);
        do_hit(hidx, got);
        model_hit(hidx, exp_kl);
        check("rand kill", got, exp_kl);
      end else begin
        hidx = $urandom_range(0, OBJ_LIMIT - 1);
        do_tick((sel >= 90) ? 1 : 0, hidx, br, kl);
        model_tick(exp_br);
        exp_kl = 0;
        if (sel >= 90) model_hit(hidx, exp_kl);
        check("rand breach", br, exp_br);
        check("rand tick kill", kl, exp_kl);
      end
      check_state("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
